usb_link_arbiter: RTL
=====================

USB_LINK_ARBITER -- requirements
Module: usb_link_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DEBOUNCE, 16: consecutive high cycles before a link request is qualified (2..255).
- DRAIN_MAX, 255: DRAIN timeout in cycles (1..255).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- ext_clk, in, 1: sole clock; all logic on rising edge.
- reset_n, in, 1: reset, asynchronous, active-low.
- u3_link_up, in, 1: USB 3.0 core link active.
- u2_connected, in, 1: USB 2.0 core stat_connected.
- buf_in_wren / buf_in_commit / buf_out_arm, in, 1 each: user strobes.
- {u3,u2}_buf_in_wren / _buf_in_commit / _buf_out_arm, out, 1 each: gated strobes to each core.
- {u3,u2}_buf_in_ready / _buf_in_commit_ack / _buf_out_hasdata / _buf_out_arm_ack / _vend_req_act, in, 1 each: core status.
- {u3,u2}_buf_out_len, in, 11: core OUT length.
- {u3,u2}_buf_out_q, in, 8: core OUT data.
- {u3,u2}_vend_req_request, in, 8: core vendor request.
- {u3,u2}_vend_req_val, in, 16: core vendor value.
- buf_in_ready / buf_in_commit_ack / buf_out_hasdata / buf_out_arm_ack / vend_req_act, out, 1 each: muxed status to user.
- buf_out_len, out, 11: muxed OUT length.
- buf_out_q, out, 8: muxed OUT data.
- vend_req_request, out, 8: muxed vendor request.
- vend_req_val, out, 16: muxed vendor value.
- owner, out, 2: 00 none, 01 USB3, 10 USB2; 11 never driven.
- err_drain_timeout, out, 1: one-cycle pulse on DRAIN timeout.
- switch_count, out, 8: ownership grant counter.

Function
REQ-003 Qualifiers u3_q/u2_q SHALL assert after their input has been high DEBOUNCE consecutive cycles, and deassert in the cycle after the input goes low.
REQ-004 The FSM SHALL have states IDLE, OWN_U3, OWN_U2 and DRAIN, with all state and owner changes registered.
REQ-005 IDLE SHALL go to OWN_U3 if u3_q, else to OWN_U2 if u2_q; USB3 has priority when both are qualified.
REQ-006 OWN_U3 SHALL go to DRAIN when u3_q is low.
REQ-007 OWN_U2 SHALL go to DRAIN when u2_q is low or u3_q is high (USB3 preempts USB2).
REQ-008 DRAIN SHALL go to IDLE when commit_pend and arm_pend are both clear, or when the drain counter reaches DRAIN_MAX.
REQ-009 On DRAIN timeout, the block SHALL pulse err_drain_timeout for 1 cycle and clear both pending flags.
REQ-010 In OWN_x, user strobes SHALL be forwarded combinationally (0 latency) to core x only; the other core's strobes SHALL be 0.
REQ-011 In IDLE and DRAIN, all core strobe outputs SHALL be 0, and user strobes are dropped.
REQ-012 Status outputs SHALL be combinationally muxed from the owner's core.
REQ-013 With owner none, buf_in_ready, buf_out_hasdata and vend_req_act SHALL be 0, and all buses SHALL be 0.
REQ-014 In DRAIN, buf_in_commit_ack and buf_out_arm_ack SHALL still be forwarded from the previous owner; all other status outputs SHALL read 0.
REQ-015 commit_pend SHALL set on a forwarded commit and clear on the previous owner's commit_ack; arm_pend SHALL behave the same with arm and arm_ack.
- If set and clear coincide, clear wins.
REQ-016 A strobe in the same cycle that the owner's qualifier drops SHALL still be forwarded, and its pending flag set before DRAIN is entered.
REQ-017 The drain counter SHALL be 8-bit, zeroed on DRAIN entry, and SHALL not wrap.
REQ-018 Each entry into OWN_U3 or OWN_U2 SHALL increment switch_count, saturating at 255.

Reset
REQ-019 When reset_n is low, the block SHALL asynchronously force the following, and remove reset synchronously on the next ext_clk edge:
- state IDLE, owner 00.
- Qualifiers, debounce counters, pending flags and drain counter to 0.
- err_drain_timeout 0, switch_count 0.
- All core strobes 0.
REQ-020 Reset mid-transaction SHALL discard pending state without issuing any ack to the user.

Configuration
REQ-021 The block SHALL compile switch_count logic only when USB_LINK_ARB_STATS_EN is defined, counting per REQ-018.
REQ-022 Without USB_LINK_ARB_STATS_EN, switch_count SHALL be tied to 8'h00, and no counter flops SHALL exist.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- u2_connected high 15 cycles, then low -> owner stays 00. Held 16 cycles -> owner=10 one cycle later; u2 strobes follow user strobes.
- u3_link_up and u2_connected rise together -> owner=01; u2_buf_in_wren stays 0 under user wren.
- While owner=10, u3_link_up held 16 cycles -> DRAIN (owner=00), then IDLE, then owner=01.
  - With USB_LINK_ARB_STATS_EN, switch_count=2.
- Commit in the cycle u3_link_up drops; u3 commit_ack 5 cycles later -> buf_in_commit_ack pulses through; IDLE follows; no timeout.
- Arm forwarded, link drops, no arm_ack ever -> err_drain_timeout pulses exactly 255 cycles after DRAIN entry; then IDLE.
- reset_n asserted in DRAIN with commit_pend set -> owner=00, all strobes 0, no ack after release.

Source files
------------

// File: rtl/usb_link_arbiter_if.sv
// Bus bundle between the user logic, the USB3/USB2 cores and usb_link_arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface usb_link_arbiter_if;
  // Core link status
  logic        u3_link_up;
  logic        u2_connected;

  // User strobes
  logic        buf_in_wren;
  logic        buf_in_commit;
  logic        buf_out_arm;

  // Gated strobes towards each core
  logic        u3_buf_in_wren;
  logic        u3_buf_in_commit;
  logic        u3_buf_out_arm;
  logic        u2_buf_in_wren;
  logic        u2_buf_in_commit;
  logic        u2_buf_out_arm;

  // Core status
  logic        u3_buf_in_ready;
  logic        u3_buf_in_commit_ack;
  logic        u3_buf_out_hasdata;
  logic        u3_buf_out_arm_ack;
  logic        u3_vend_req_act;
  logic [10:0] u3_buf_out_len;
  logic [7:0]  u3_buf_out_q;
  logic [7:0]  u3_vend_req_request;
  logic [15:0] u3_vend_req_val;
  logic        u2_buf_in_ready;
  logic        u2_buf_in_commit_ack;
  logic        u2_buf_out_hasdata;
  logic        u2_buf_out_arm_ack;
  logic        u2_vend_req_act;
  logic [10:0] u2_buf_out_len;
  logic [7:0]  u2_buf_out_q;
  logic [7:0]  u2_vend_req_request;
  logic [15:0] u2_vend_req_val;

  // Muxed status towards the user
  logic        buf_in_ready;
  logic        buf_in_commit_ack;
  logic        buf_out_hasdata;
  logic        buf_out_arm_ack;
  logic        vend_req_act;
  logic [10:0] buf_out_len;
  logic [7:0]  buf_out_q;
  logic [7:0]  vend_req_request;
  logic [15:0] vend_req_val;

  // Arbiter observability
  logic [1:0]  owner;
  logic        err_drain_timeout;
  logic [7:0]  switch_count;

  modport slave (
    input  u3_link_up, u2_connected,
    input  buf_in_wren, buf_in_commit, buf_out_arm,
    output u3_buf_in_wren, u3_buf_in_commit, u3_buf_out_arm,
    output u2_buf_in_wren, u2_buf_in_commit, u2_buf_out_arm,
    input  u3_buf_in_ready, u3_buf_in_commit_ack, u3_buf_out_hasdata, u3_buf_out_arm_ack,
    input  u3_vend_req_act, u3_buf_out_len, u3_buf_out_q, u3_vend_req_request, u3_vend_req_val,
    input  u2_buf_in_ready, u2_buf_in_commit_ack, u2_buf_out_hasdata, u2_buf_out_arm_ack,
    input  u2_vend_req_act, u2_buf_out_len, u2_buf_out_q, u2_vend_req_request, u2_vend_req_val,
    output buf_in_ready, buf_in_commit_ack, buf_out_hasdata, buf_out_arm_ack, vend_req_act,
    output buf_out_len, buf_out_q, vend_req_request, vend_req_val,
    output owner, err_drain_timeout, switch_count
  );

  modport master (
    output u3_link_up, u2_connected,
    output buf_in_wren, buf_in_commit, buf_out_arm,
    input  u3_buf_in_wren, u3_buf_in_commit, u3_buf_out_arm,
    input  u2_buf_in_wren, u2_buf_in_commit, u2_buf_out_arm,
    output u3_buf_in_ready, u3_buf_in_commit_ack, u3_buf_out_hasdata, u3_buf_out_arm_ack,
    output u3_vend_req_act, u3_buf_out_len, u3_buf_out_q, u3_vend_req_request, u3_vend_req_val,
    output u2_buf_in_ready, u2_buf_in_commit_ack, u2_buf_out_hasdata, u2_buf_out_arm_ack,
    output u2_vend_req_act, u2_buf_out_len, u2_buf_out_q, u2_vend_req_request, u2_vend_req_val,
    input  buf_in_ready, buf_in_commit_ack, buf_out_hasdata, buf_out_arm_ack, vend_req_act,
    input  buf_out_len, buf_out_q, vend_req_request, vend_req_val,
    input  owner, err_drain_timeout, switch_count
  );
endinterface

// File: rtl/usb_link_arbiter.sv
// Arbitrates a single user buffer port between a USB3 and a USB2 device core.
// USB3 wins ties and preempts USB2. On loss of link the arbiter drains any
// outstanding commit/arm until acknowledged or until DRAIN_MAX cycles pass.
// Optional: define USB_LINK_ARB_STATS_EN to build the switch_count grant counter.
module usb_link_arbiter #(
  parameter int unsigned DEBOUNCE  = 16,
  parameter int unsigned DRAIN_MAX = 255
) (
  input logic               ext_clk,
  input logic               reset_n,
  usb_link_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StOwnU3, StOwnU2, StDrain} state_e;

  localparam logic [7:0] DebLast   = 8'(DEBOUNCE - 1);
  localparam logic [7:0] DrainLast = 8'(DRAIN_MAX - 1);

  state_e     state_q, state_d;
  logic       prev_u3_q, prev_u3_d;
  logic [7:0] deb3_q, deb3_d, deb2_q, deb2_d;
  logic       u3_qual_q, u3_qual_d, u2_qual_q, u2_qual_d;
  logic       commit_pend_q, commit_pend_d;
  logic       arm_pend_q, arm_pend_d;
  logic [7:0] drain_cnt_q, drain_cnt_d;
  logic       err_q, err_d;

  logic own_u3, own_u2, in_drain, sel_u3, sel_u2;
  logic fwd_commit, fwd_arm, commit_ack_sel, arm_ack_sel, timeout;

  assign own_u3   = (state_q == StOwnU3);
  assign own_u2   = (state_q == StOwnU2);
  assign in_drain = (state_q == StDrain);
  // During DRAIN the acks still come from whichever core owned the port last.
  assign sel_u3   = own_u3 | (in_drain & prev_u3_q);
  assign sel_u2   = own_u2 | (in_drain & ~prev_u3_q);

  // Debounce: qualifier rises on the DEBOUNCE-th consecutive high sample.
  always_comb begin
    deb3_d    = deb3_q;
    u3_qual_d = u3_qual_q;
    deb2_d    = deb2_q;
    u2_qual_d = u2_qual_q;
    if (!bus.u3_link_up) begin
      deb3_d    = '0;
      u3_qual_d = 1'b0;
    end else if (deb3_q == DebLast) begin
      u3_qual_d = 1'b1;
    end else begin
      deb3_d = deb3_q + 8'd1;
    end
    if (!bus.u2_connected) begin
      deb2_d    = '0;
      u2_qual_d = 1'b0;
    end else if (deb2_q == DebLast) begin
      u2_qual_d = 1'b1;
    end else begin
      deb2_d = deb2_q + 8'd1;
    end
  end

  // Zero-latency strobe gating towards the owning core only.
  assign bus.u3_buf_in_wren   = own_u3 & bus.buf_in_wren;
  assign bus.u3_buf_in_commit = own_u3 & bus.buf_in_commit;
  assign bus.u3_buf_out_arm   = own_u3 & bus.buf_out_arm;
  assign bus.u2_buf_in_wren   = own_u2 & bus.buf_in_wren;
  assign bus.u2_buf_in_commit = own_u2 & bus.buf_in_commit;
  assign bus.u2_buf_out_arm   = own_u2 & bus.buf_out_arm;

  assign fwd_commit     = (own_u3 | own_u2) & bus.buf_in_commit;
  assign fwd_arm        = (own_u3 | own_u2) & bus.buf_out_arm;
  assign commit_ack_sel = (sel_u3 & bus.u3_buf_in_commit_ack) |
                          (sel_u2 & bus.u2_buf_in_commit_ack);
  assign arm_ack_sel    = (sel_u3 & bus.u3_buf_out_arm_ack) | (sel_u2 & bus.u2_buf_out_arm_ack);
  assign timeout        = in_drain & (commit_pend_q | arm_pend_q) & (drain_cnt_q == DrainLast);

  // Status mux: full view of the owner, acks only while draining, zero otherwise.
  always_comb begin
    bus.buf_in_ready      = 1'b0;
    bus.buf_out_hasdata   = 1'b0;
    bus.vend_req_act      = 1'b0;
    bus.buf_out_len       = '0;
    bus.buf_out_q         = '0;
    bus.vend_req_request  = '0;
    bus.vend_req_val      = '0;
    bus.buf_in_commit_ack = commit_ack_sel;
    bus.buf_out_arm_ack   = arm_ack_sel;
    if (own_u3) begin
      bus.buf_in_ready     = bus.u3_buf_in_ready;
      bus.buf_out_hasdata  = bus.u3_buf_out_hasdata;
      bus.vend_req_act     = bus.u3_vend_req_act;
      bus.buf_out_len      = bus.u3_buf_out_len;
      bus.buf_out_q        = bus.u3_buf_out_q;
      bus.vend_req_request = bus.u3_vend_req_request;
      bus.vend_req_val     = bus.u3_vend_req_val;
    end else if (own_u2) begin
      bus.buf_in_ready     = bus.u2_buf_in_ready;
      bus.buf_out_hasdata  = bus.u2_buf_out_hasdata;
      bus.vend_req_act     = bus.u2_vend_req_act;
      bus.buf_out_len      = bus.u2_buf_out_len;
      bus.buf_out_q        = bus.u2_buf_out_q;
      bus.vend_req_request = bus.u2_vend_req_request;
      bus.vend_req_val     = bus.u2_vend_req_val;
    end
  end

  // Next-state logic for ownership, pending flags and the drain timer.
  always_comb begin
    state_d     = state_q;
    prev_u3_d   = prev_u3_q;
    drain_cnt_d = drain_cnt_q;
    err_d       = timeout;
    // Clear beats set when a forward and an ack land in the same cycle.
    commit_pend_d = commit_ack_sel ? 1'b0 : (commit_pend_q | fwd_commit);
    arm_pend_d    = arm_ack_sel ? 1'b0 : (arm_pend_q | fwd_arm);
    if (timeout) begin
      commit_pend_d = 1'b0;
      arm_pend_d    = 1'b0;
    end
    unique case (state_q)
      StIdle: begin
        if (u3_qual_q) begin
          state_d = StOwnU3;
        end else if (u2_qual_q) begin
          state_d = StOwnU2;
        end
      end
      StOwnU3: begin
        if (!u3_qual_q) begin
          state_d     = StDrain;
          prev_u3_d   = 1'b1;
          drain_cnt_d = '0;
        end
      end
      StOwnU2: begin
        if (!u2_qual_q || u3_qual_q) begin
          state_d     = StDrain;
          prev_u3_d   = 1'b0;
          drain_cnt_d = '0;
        end
      end
      StDrain: begin
        if (!(commit_pend_q || arm_pend_q) || timeout) begin
          state_d = StIdle;
        end
        if (drain_cnt_q != 8'hFF) begin
          drain_cnt_d = drain_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.owner             = {own_u2, own_u3};
  assign bus.err_drain_timeout = err_q;

  // State register with asynchronous reset.
  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      prev_u3_q     <= 1'b0;
      deb3_q        <= '0;
      deb2_q        <= '0;
      u3_qual_q     <= 1'b0;
      u2_qual_q     <= 1'b0;
      commit_pend_q <= 1'b0;
      arm_pend_q    <= 1'b0;
      drain_cnt_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_u3_q     <= prev_u3_d;
      deb3_q        <= deb3_d;
      deb2_q        <= deb2_d;
      u3_qual_q     <= u3_qual_d;
      u2_qual_q     <= u2_qual_d;
      commit_pend_q <= commit_pend_d;
      arm_pend_q    <= arm_pend_d;
      drain_cnt_q   <= drain_cnt_d;
      err_q         <= err_d;
    end
  end

`ifdef USB_LINK_ARB_STATS_EN
  logic       grant;
  logic [7:0] switch_cnt_q, switch_cnt_d;

  assign grant = (state_q == StIdle) && (state_d != StIdle);

  // Saturating count of ownership grants.
  always_comb begin
    switch_cnt_d = switch_cnt_q;
    if (grant && switch_cnt_q != 8'hFF) begin
      switch_cnt_d = switch_cnt_q + 8'd1;
    end
  end

  // Grant counter register.
  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      switch_cnt_q <= '0;
    end else begin
      switch_cnt_q <= switch_cnt_d;
    end
  end

  assign bus.switch_count = switch_cnt_q;
`else
  assign bus.switch_count = 8'h00;
`endif

endmodule
